// File: rtl/serial_rx.sv
// Receiver for the single-wire, one-bit-per-clock serial link: start bit, 8*L data bits LSB first, stop bit.
// Received bytes are parked in a holding buffer and drained oldest-first over a valid/get handshake.
module serial_rx #(
  parameter int MAX_BYTES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] len,
  output logic [7:0] data,
  output logic       valid,
  input  logic       get,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int SW = 8 * MAX_BYTES;
  localparam int CNT_W = $clog2(SW + 1);
  localparam logic [2:0] MAX_L = 3'(MAX_BYTES);

  typedef enum logic [1:0] {HUNT, IDLE, DATA, STOP} state_t;

  state_t           r_state;
  logic [2:0]       r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    r_shift;
  logic [SW-1:0]    r_hold;
  logic [2:0]       r_rem;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_ferr;
  logic             r_ovr;

  logic [2:0]       w_len_c;
  logic [CNT_W-1:0] w_shamt;
  logic [SW-1:0]    w_aligned;
  logic             w_take;
  logic             w_empty;

  assign w_len_c   = (len > MAX_L) ? MAX_L : len;
  // A short frame occupies only the top 8*L bits of the right-shifting register.
  assign w_shamt   = CNT_W'(SW) - CNT_W'({r_len, 3'b000});
  assign w_aligned = r_shift >> w_shamt;
  assign w_take    = r_valid && get;
  assign w_empty   = !r_valid || (w_take && (r_rem == 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_len   <= 3'd0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_rem   <= 3'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;

      if (w_take) begin
        if (r_rem != 3'd0) begin
          r_data <= r_hold[7:0];
          r_hold <= r_hold >> 8;
          r_rem  <= r_rem - 3'd1;
        end else begin
          r_valid <= 1'b0;
        end
      end

      case (r_state)
        HUNT: begin
          if (rx) r_state <= IDLE;
        end
        IDLE: begin
          if (!rx) begin
            r_len   <= w_len_c;
            r_cnt   <= CNT_W'({w_len_c, 3'b000});
            r_busy  <= 1'b1;
            r_state <= (w_len_c == 3'd0) ? STOP : DATA;
          end
        end
        DATA: begin
          r_shift <= {rx, r_shift[SW-1:1]};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= STOP;
        end
        STOP: begin
          r_busy <= 1'b0;
          if (rx) begin
            r_state <= IDLE;
            // A load here overrides the drain above; the held bytes are all consumed or absent.
            if (r_len != 3'd0) begin
              if (w_empty) begin
                r_data  <= w_aligned[7:0];
                r_hold  <= w_aligned >> 8;
                r_rem   <= r_len - 3'd1;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end
          end else begin
            r_ferr  <= 1'b1;
            r_state <= HUNT;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: expected bytes are queued as frames are driven and
// compared whenever the receiver hands a byte out.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [2:0] len;
  logic [7:0] data;
  logic       valid;
  logic       get;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  logic [7:0] sb_q[$];
  logic prev_ferr = 1'b0;
  logic prev_ovr  = 1'b0;

  serial_rx #(.MAX_BYTES(6)) dut (
    .clk(clk), .rst(rst), .rx(rx), .len(len), .data(data), .valid(valid),
    .get(get), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid && get) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected: observed %0h expected no byte", data);
        end else begin
          check("sb_data", 32'(data), 32'(sb_q.pop_front()));
        end
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      check("pulse_width", {30'd0, frame_err & prev_ferr, overrun & prev_ovr}, 32'd0);
    end
    prev_ferr <= frame_err;
    prev_ovr  <= overrun;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the stop-bit edge with the line idle high.
  task automatic send_frame(input logic [2:0] l, input int nbytes, input logic [47:0] bytes,
                            input logic stopb);
    len = l;
    rx  = 1'b0;
    tick();
    check("busy_start", 32'(busy), 32'd1);
    for (int k = 0; k < 8 * nbytes; k++) begin
      rx = bytes[k];
      tick();
    end
    rx = stopb;
    tick();
    check("busy_after_stop", 32'(busy), 32'd0);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    get = 1'b0;
    len = 3'd0;
    repeat (2) tick();
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // Single byte 0xA5 with get held high
    get = 1'b1;
    sb_q.push_back(8'hA5);
    send_frame(3'd1, 1, 48'hA5, 1'b1);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_data", 32'(data), 32'hA5);
    tick();
    check("t1_valid_drop", 32'(valid), 32'd0);
    check("t1_nferr", 32'(n_ferr), 32'd0);
    check("t1_novr", 32'(n_ovr), 32'd0);

    // Three bytes with a 5-cycle stall
    get = 1'b0;
    sb_q.push_back(8'h12);
    sb_q.push_back(8'h34);
    sb_q.push_back(8'h56);
    send_frame(3'd3, 3, 48'h563412, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_data", 32'(data), 32'h12);
      check("t2_stall_valid", 32'(valid), 32'd1);
      tick();
    end
    get = 1'b1;
    check("t2_b0", 32'(data), 32'h12);
    tick();
    check("t2_b1", 32'(data), 32'h34);
    tick();
    check("t2_b2", 32'(data), 32'h56);
    tick();
    check("t2_valid_drop", 32'(valid), 32'd0);
    check("t2_data_hold", 32'(data), 32'h56);

    // Back-to-back frames, consumer keeping up
    sb_q.push_back(8'h0F);
    sb_q.push_back(8'hF0);
    send_frame(3'd1, 1, 48'h0F, 1'b1);
    tick();
    send_frame(3'd1, 1, 48'hF0, 1'b1);
    tick();
    tick();
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);
    check("t3_novr", 32'(n_ovr), 32'd0);

    // Back-to-back frames with consumer stalled: second frame overruns
    get = 1'b0;
    sb_q.push_back(8'h0F);
    send_frame(3'd1, 1, 48'h0F, 1'b1);
    tick();
    send_frame(3'd1, 1, 48'hF0, 1'b1);
    check("t4_ovr_pulse", 32'(overrun), 32'd1);
    check("t4_data_kept", 32'(data), 32'h0F);
    check("t4_valid", 32'(valid), 32'd1);
    tick();
    check("t4_ovr_clear", 32'(overrun), 32'd0);
    check("t4_data_still", 32'(data), 32'h0F);
    check("t4_novr", 32'(n_ovr), 32'd1);
    get = 1'b1;
    tick();
    get = 1'b0;
    check("t4_valid_drop", 32'(valid), 32'd0);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Framing error, then hunting with the line held low
    get = 1'b1;
    send_frame(3'd1, 1, 48'h00, 1'b0);
    check("t5_ferr_pulse", 32'(frame_err), 32'd1);
    check("t5_no_valid", 32'(valid), 32'd0);
    rx = 1'b0;
    tick();
    check("t5_ferr_clear", 32'(frame_err), 32'd0);
    check("t5_nferr", 32'(n_ferr), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("t5_hunt_busy", 32'(busy), 32'd0);
      check("t5_hunt_valid", 32'(valid), 32'd0);
      tick();
    end
    rx = 1'b1;
    tick();
    sb_q.push_back(8'h5A);
    send_frame(3'd1, 1, 48'h5A, 1'b1);
    check("t5_valid", 32'(valid), 32'd1);
    check("t5_data", 32'(data), 32'h5A);
    tick();

    // Zero-length frame
    tick();
    send_frame(3'd0, 0, 48'h0, 1'b1);
    check("t6_no_valid", 32'(valid), 32'd0);
    check("t6_no_ferr", 32'(frame_err), 32'd0);
    check("t6_no_ovr", 32'(overrun), 32'd0);
    tick();

    // Reset mid-frame, line held low afterwards, then a clamped len=7 frame
    get = 1'b0;
    len = 3'd2;
    rx  = 1'b0;
    tick();
    rx = 1'b1;
    tick();
    rx = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t7_rst_data", 32'(data), 32'd0);
    check("t7_rst_valid", 32'(valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t7_hunt_busy", 32'(busy), 32'd0);
      check("t7_hunt_valid", 32'(valid), 32'd0);
      tick();
    end
    rx = 1'b1;
    tick();
    get = 1'b1;
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    sb_q.push_back(8'h33);
    sb_q.push_back(8'h44);
    sb_q.push_back(8'h55);
    sb_q.push_back(8'h66);
    send_frame(3'd7, 6, 48'h665544332211, 1'b1);
    check("t7_valid", 32'(valid), 32'd1);
    check("t7_data0", 32'(data), 32'h11);
    repeat (6) tick();
    check("t7_valid_drop", 32'(valid), 32'd0);
    check("t7_data_last", 32'(data), 32'h66);
    check("t7_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_nferr", 32'(n_ferr), 32'd1);
    check("final_novr", 32'(n_ovr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
